serial_add_sub: RTL

Parametrised multi-cycle adder/subtractor. It processes two WIDTH-bit operands DIGIT bits per clock using a DIGIT-bit ripple slice built from the team's full-adder cells, with a registered carry between digits. A start/busy/done handshake frames each operation. It is the area-lean arithmetic unit for datapaths where latency is acceptable, and it adds subtract mode plus carry-out and signed-overflow flags.

---
 rtl/serial_add_sub.sv | 116 +++++++++++
 1 files changed

// File: rtl/serial_add_sub.sv
// serial_add_sub: digit-serial adder/subtractor.
// Each RUN cycle adds the low DIGIT bits of the two operand shift registers
// through a ripple slice. The slice carry is registered between digits, so the
// critical path is one DIGIT-bit ripple and does not depend on WIDTH.
// WIDTH must be >= 2 and an integer multiple of DIGIT.
//
// state | meaning
// IDLE  | waiting for start; the previous result is held on sum/cout/overflow
// RUN   | one digit is processed per cycle; start is ignored
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic [DIGIT-1:0] slice_sum;
  logic             slice_cout;
  logic             cin_msb;
  logic             cy;
  logic [WIDTH-1:0] res_next;

  // Ripple slice: each iteration is one full-adder cell; cin_msb keeps the
  // carry entering the top bit of the digit for the signed-overflow flag.
  always_comb begin
    cy        = carry;
    cin_msb   = carry;
    slice_sum = '0;
    for (int i = 0; i < DIGIT; i++) begin
      cin_msb      = cy;
      slice_sum[i] = a_sr[i] ^ b_sr[i] ^ cy;
      cy           = (a_sr[i] & b_sr[i]) | (cy & (a_sr[i] ^ b_sr[i]));
    end
    slice_cout = cy;
  end

  // New digit enters the result register from the top, so after N digits the
  // least significant digit has reached bit 0.
  assign res_next = (res_sr >> DIGIT) | (WIDTH'(slice_sum) << (WIDTH - DIGIT));

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + ~borrow_in.
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub ? ~cin : cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> DIGIT;
          b_sr   <= b_sr >> DIGIT;
          res_sr <= res_next;
          carry  <= slice_cout;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum      <= res_next;
            cout     <= slice_cout;
            overflow <= cin_msb ^ slice_cout;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
